dscale_ctrl: RTL
================

DSCALE_CTRL -- requirements
Module: dscale_ctrl

Interface
REQ-001 SHALL have parameter DEF_W, default 1280, meaning the reset-time active input/output width.
REQ-002 SHALL have parameter DEF_H, default 960, meaning the reset-time active input/output height.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports: pclk in 1, clock; rst in 1, reset.
REQ-004 SHALL have ports: cfg_valid in 1, request strobe; cfg_ready out 1, request accepted when high with cfg_valid; cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h in 12 each, requested resolutions.
REQ-005 SHALL have ports: in_vsync in 1, frame sync; pending out 1, computed config awaiting commit; commit out 1, one-cycle apply pulse; cfg_err out 1, one-cycle reject pulse.
REQ-006 SHALL have ports: dscale_w, dscale_h out 3 each, decimation factors; s_in_crop_w, s_in_crop_h, s_out_crop_w, s_out_crop_h out 12 each, crop settings for the downscaler.

Function
REQ-007 SHALL run FSM IDLE -> FACT_W -> FACT_H -> DIV_W -> DIV_H -> PEND -> IDLE; cfg_ready=1 only in IDLE.
REQ-008 SHALL capture the four cfg_* values on the cycle cfg_valid&cfg_ready and move to FACT_W.
REQ-009 SHALL compute f=floor(in/out) by repeated subtraction, clamped to 1..7, in FACT_W and FACT_H; each state lasts exactly 8 cycles.
REQ-010 SHALL compute scaled=floor(in/f) with a 12-cycle restoring divider in DIV_W and DIV_H; each state lasts exactly 12 cycles.
REQ-011 SHALL enter PEND exactly 40 cycles after the accept cycle; pending=1 throughout PEND.
REQ-012 SHALL set shadow s_in_crop = scaled and s_out_crop = min(cfg_out, scaled), per axis.
REQ-013 SHALL detect frame_start as registered-prev in_vsync=1 and current in_vsync=0.
REQ-014 SHALL, in PEND on the frame_start cycle, load all six active outputs on that edge, pulse commit the next cycle, and return to IDLE.
REQ-015 SHALL never change active outputs except on commit or reset, so a frame always sees one coherent configuration.
REQ-016 SHALL ignore frame_start outside PEND; if frame_start coincides with PEND entry, the commit waits for the next frame_start.
REQ-017 SHALL hold cfg_ready=0 in all non-IDLE states; a cfg_valid held high is accepted on return to IDLE.

Reset
REQ-018 SHALL on rst force IDLE, cfg_ready=1, pending=0, commit=0, cfg_err=0, dscale_w=dscale_h=1, s_in_crop_w=s_out_crop_w=DEF_W, s_in_crop_h=s_out_crop_h=DEF_H.
REQ-019 SHALL discard any in-flight or pending configuration when rst asserts mid-operation.

Configuration
REQ-020 SHALL, with DSCALE_CTRL_CHECK_EN defined, reject a request with any out==0, out>in, or in>=8*out: no FSM advance, cfg_err pulses the cycle after accept, actives unchanged.
REQ-021 SHALL, without DSCALE_CTRL_CHECK_EN, accept every request, apply the REQ-009 clamp, and tie cfg_err to 0.

Structure
REQ-022 SHALL place the FSM state enum, the FACT/DIV cycle-count constants (8, 12) and the 12-bit dimension width in a shared package dscale_pkg.
REQ-023 SHALL implement the divider as sub-module dscale_div12 (start/done, 12-bit dividend, 3-bit divisor, fixed 12 cycles), instantiated once and time-shared between axes.

Verification
REQ-024 SHALL test 1280x960 -> 640x480: after one frame_start, dscale 2/2, s_in_crop 640x480, s_out_crop 640x480, commit pulses once.
REQ-025 SHALL test 1280x960 -> 400x300: dscale 3/3, s_in_crop 426x320, s_out_crop 400x300; actives unchanged before the vsync falling edge.
REQ-026 SHALL test 1280 -> 100 width: with CHECK_EN cfg_err=1 and actives unchanged; without it dscale_w=7, s_in_crop_w=182, s_out_crop_w=100.
REQ-027 SHALL test cfg_valid held during computation: cfg_ready=0 for 40 cycles plus PEND, second request accepted in the first IDLE cycle.
REQ-028 SHALL test rst asserted in PEND: pending=0, actives at 1/1 and 1280x960, no commit on the following frame_start.
REQ-029 SHALL test out_w=1400 > in_w=1280 without CHECK_EN: dscale_w=1, s_in_crop_w=1280, s_out_crop_w=1280.

Source files
------------

// File: rtl/dscale_pkg.sv
// Shared definitions for the downscaler configuration controller:
// FSM state encoding, phase lengths, dimension width and small helpers.
package dscale_pkg;

  localparam int DIM_W    = 12;
  localparam int FACT_CYC = 8;
  localparam int DIV_CYC  = 12;
  localparam int FACT_MAX = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FACT_W,
    ST_FACT_H,
    ST_DIV_W,
    ST_DIV_H,
    ST_PEND
  } state_t;

  function automatic logic [DIM_W-1:0] dim_min(input logic [DIM_W-1:0] a,
                                               input logic [DIM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // An axis is unusable when it has no output, upscales, or needs a factor above 7.
  function automatic logic axis_bad(input logic [DIM_W-1:0] in_dim,
                                    input logic [DIM_W-1:0] out_dim);
    logic [DIM_W+2:0] in_ext;
    logic [DIM_W+2:0] out_x8;
    in_ext = {3'b000, in_dim};
    out_x8 = {out_dim, 3'b000};
    return (out_dim == '0) || (out_dim > in_dim) || (in_ext >= out_x8);
  endfunction

endpackage

// File: rtl/dscale_div12.sv
// Fixed-latency restoring divider: 12-bit dividend by 3-bit divisor.
// The first quotient bit is resolved in the start cycle straight from the
// inputs, so the full quotient is presented (with done) in the 12th cycle
// counted from start, and a new start may be issued on the following cycle.
module dscale_div12
  import dscale_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] dividend,
  input  logic [2:0]       divisor,
  output logic             done,
  output logic [DIM_W-1:0] quotient
);

  logic             busy;
  logic [3:0]       cnt;
  logic [2:0]       rem_q;
  logic [DIM_W-1:0] quo_q;
  logic [2:0]       dvs_q;

  logic [2:0]       src_rem;
  logic [DIM_W-1:0] src_quo;
  logic [2:0]       src_dvs;
  logic [3:0]       trial;
  logic [3:0]       diff;
  logic             ge;
  logic [2:0]       rem_nx;
  logic [DIM_W-1:0] quo_nx;

  // One restoring iteration, fed from the inputs on start, else from the registers.
  always_comb begin
    src_rem = start ? 3'd0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[DIM_W-1]};
    diff    = trial - {1'b0, src_dvs};
    ge      = (trial >= {1'b0, src_dvs});
    rem_nx  = ge ? diff[2:0] : trial[2:0];
    quo_nx  = {src_quo[DIM_W-2:0], ge};
  end

  assign done     = busy && (cnt == 4'(DIV_CYC - 1));
  assign quotient = quo_nx;

  // Iteration sequencing: start performs iteration 1, busy cycles the rest.
  always_ff @(posedge pclk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 4'd1;
    end else if (busy) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'(DIV_CYC - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  // Partial remainder / quotient shift register, no reset needed.
  always_ff @(posedge pclk) begin
    if (start || busy) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
    if (start) begin
      dvs_q <= divisor;
    end
  end

endmodule

// File: rtl/dscale_ctrl.sv
// Downscaler configuration controller. Accepts a resolution request,
// derives per-axis decimation factors and crop sizes over a fixed 40-cycle
// computation, then holds the result pending until the next frame start
// (falling edge of in_vsync) so a frame never sees a mixed configuration.
// Optional build macro DSCALE_CTRL_CHECK_EN: reject unusable requests with a
// one-cycle cfg_err pulse instead of clamping them.
module dscale_ctrl
  import dscale_pkg::*;
#(
  parameter int unsigned DEF_W = 1280,
  parameter int unsigned DEF_H = 960
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_in_w,
  input  logic [DIM_W-1:0] cfg_in_h,
  input  logic [DIM_W-1:0] cfg_out_w,
  input  logic [DIM_W-1:0] cfg_out_h,
  input  logic             in_vsync,
  output logic             pending,
  output logic             commit,
  output logic             cfg_err,
  output logic [2:0]       dscale_w,
  output logic [2:0]       dscale_h,
  output logic [DIM_W-1:0] s_in_crop_w,
  output logic [DIM_W-1:0] s_in_crop_h,
  output logic [DIM_W-1:0] s_out_crop_w,
  output logic [DIM_W-1:0] s_out_crop_h
);

  state_t           state;
  logic [3:0]       cnt;
  logic             vs_prev;

  logic [DIM_W-1:0] in_w_r, in_h_r, out_w_r, out_h_r;
  logic [DIM_W-1:0] rem;
  logic [2:0]       fq;
  logic [2:0]       fw, fh;
  logic [DIM_W-1:0] scaled_w, scaled_h;

  logic [DIM_W-1:0] cur_in, cur_out;
  logic             sub_ok;
  logic [2:0]       fq_nx;
  logic [DIM_W-1:0] rem_nx;
  logic [2:0]       f_final;
  logic             accept;
  logic             frame_start;
  logic             fact_last, div_last;

  logic             div_start;
  logic [DIM_W-1:0] div_dividend;
  logic [2:0]       div_divisor;
  logic             div_done;
  logic [DIM_W-1:0] div_quo;

`ifdef DSCALE_CTRL_CHECK_EN
  logic             req_bad;
  assign req_bad = axis_bad(cfg_in_w, cfg_out_w) || axis_bad(cfg_in_h, cfg_out_h);
`endif

  assign accept      = cfg_valid && cfg_ready;
  assign frame_start = vs_prev && !in_vsync;
  assign fact_last   = (cnt == 4'(FACT_CYC - 1));
  assign div_last    = (cnt == 4'(DIV_CYC - 1));

  // Factor search step: one subtraction per cycle, saturating at the max factor.
  always_comb begin
    cur_in  = (state == ST_FACT_H) ? in_h_r : in_w_r;
    cur_out = (state == ST_FACT_H) ? out_h_r : out_w_r;
    sub_ok  = (rem >= cur_out) && (fq != 3'(FACT_MAX));
    fq_nx   = sub_ok ? fq + 3'd1 : fq;
    rem_nx  = sub_ok ? rem - cur_out : rem;
    f_final = (fq_nx == 3'd0) ? 3'd1 : fq_nx;
  end

  assign div_start    = ((state == ST_DIV_W) || (state == ST_DIV_H)) && (cnt == 4'd0);
  assign div_dividend = (state == ST_DIV_H) ? in_h_r : in_w_r;
  assign div_divisor  = (state == ST_DIV_H) ? fh : fw;

  dscale_div12 u_div (
    .pclk     (pclk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Control FSM with registered handshake/status outputs and the active register set.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      vs_prev      <= 1'b0;
      cfg_ready    <= 1'b1;
      pending      <= 1'b0;
      commit       <= 1'b0;
      cfg_err      <= 1'b0;
      dscale_w     <= 3'd1;
      dscale_h     <= 3'd1;
      s_in_crop_w  <= DIM_W'(DEF_W);
      s_out_crop_w <= DIM_W'(DEF_W);
      s_in_crop_h  <= DIM_W'(DEF_H);
      s_out_crop_h <= DIM_W'(DEF_H);
    end else begin
      vs_prev <= in_vsync;
      commit  <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef DSCALE_CTRL_CHECK_EN
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else begin
              state     <= ST_FACT_W;
              cnt       <= '0;
              cfg_ready <= 1'b0;
            end
`else
            state     <= ST_FACT_W;
            cnt       <= '0;
            cfg_ready <= 1'b0;
`endif
          end
        end
        ST_FACT_W: begin
          if (fact_last) begin
            state <= ST_FACT_H;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_FACT_H: begin
          if (fact_last) begin
            state <= ST_DIV_W;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DIV_W: begin
          if (div_last) begin
            state <= ST_DIV_H;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DIV_H: begin
          if (div_last) begin
            state   <= ST_PEND;
            cnt     <= '0;
            pending <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_PEND: begin
          if (frame_start) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            commit       <= 1'b1;
            cfg_ready    <= 1'b1;
            dscale_w     <= fw;
            dscale_h     <= fh;
            s_in_crop_w  <= scaled_w;
            s_in_crop_h  <= scaled_h;
            s_out_crop_w <= dim_min(out_w_r, scaled_w);
            s_out_crop_h <= dim_min(out_h_r, scaled_h);
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          pending   <= 1'b0;
        end
      endcase
    end
  end

  // Working datapath: request capture, factor search and divider results.
  always_ff @(posedge pclk) begin
    if ((state == ST_IDLE) && accept) begin
      in_w_r  <= cfg_in_w;
      in_h_r  <= cfg_in_h;
      out_w_r <= cfg_out_w;
      out_h_r <= cfg_out_h;
    end
    if ((state == ST_FACT_W) || (state == ST_FACT_H)) begin
      if (cnt == 4'd0) begin
        rem <= cur_in;
        fq  <= 3'd0;
      end else begin
        rem <= rem_nx;
        fq  <= fq_nx;
        if (fact_last && (state == ST_FACT_W)) begin
          fw <= f_final;
        end
        if (fact_last && (state == ST_FACT_H)) begin
          fh <= f_final;
        end
      end
    end
    if ((state == ST_DIV_W) && div_done) begin
      scaled_w <= div_quo;
    end
    if ((state == ST_DIV_H) && div_done) begin
      scaled_h <= div_quo;
    end
  end

endmodule
